mdu_iter: RTL and testbench



---
 rtl/mdu_iter_if.sv | 29 ++
 rtl/mdu_iter.sv | 209 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the execute stage and the iterative multiply/divide unit.
// The master drives requests, flush and ack; the slave (the unit) returns ready/valid/result/busy.
interface mdu_iter_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  mdu_start;
  logic [2:0]            mdu_op;
  logic [DATA_W-1:0]     mdu_rs1;
  logic [DATA_W-1:0]     mdu_rs2;
  logic [REG_ADDR_W-1:0] mdu_rd;
  logic                  mdu_flush;
  logic                  mdu_ready;
  logic                  mdu_valid;
  logic                  mdu_ack;
  logic [DATA_W-1:0]     mdu_result;
  logic [REG_ADDR_W-1:0] mdu_rd_out;
  logic                  mdu_busy;

  modport master (
    output mdu_start, mdu_op, mdu_rs1, mdu_rs2, mdu_rd, mdu_flush, mdu_ack,
    input  mdu_ready, mdu_valid, mdu_result, mdu_rd_out, mdu_busy
  );

  modport slave (
    input  mdu_start, mdu_op, mdu_rs1, mdu_rs2, mdu_rd, mdu_flush, mdu_ack,
    output mdu_ready, mdu_valid, mdu_result, mdu_rd_out, mdu_busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit; 33 cycles accept-to-valid (1 cycle for special
// cases when MDU_FAST_PATH_EN is defined). Result held in DONE until ack; ready only when IDLE.
module mdu_iter #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 5
) (
  input  logic         mdu_clk,
  input  logic         mdu_rst,
  mdu_iter_if.slave    mdu
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              op_q, op_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]       a_q, a_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]       rs1_q, rs1_d;
  logic                    neg_q, neg_d;
  logic                    div0_q, div0_d;
  logic                    ovf_q, ovf_d;
  logic                    mzero_q, mzero_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic [REG_ADDR_W-1:0]   rd_out_q, rd_out_d;
  logic                    valid_q, valid_d;

  // Request decode: operand magnitudes, result sign and special cases
  logic              in_div, s1_signed, s2_signed, neg1, neg2;
  logic              in_neg, in_div0, in_ovf, in_mzero, in_special;
  logic [DATA_W-1:0] abs1, abs2;

  always_comb begin
    in_div    = mdu.mdu_op[2];
    s1_signed = (mdu.mdu_op == OP_MULH) || (mdu.mdu_op == OP_MULHSU) ||
                (mdu.mdu_op == OP_DIV)  || (mdu.mdu_op == OP_REM);
    s2_signed = (mdu.mdu_op == OP_MULH) || (mdu.mdu_op == OP_DIV) || (mdu.mdu_op == OP_REM);
    neg1      = s1_signed && mdu.mdu_rs1[DATA_W-1];
    neg2      = s2_signed && mdu.mdu_rs2[DATA_W-1];
    abs1      = neg1 ? -mdu.mdu_rs1 : mdu.mdu_rs1;
    abs2      = neg2 ? -mdu.mdu_rs2 : mdu.mdu_rs2;
    in_neg    = (mdu.mdu_op == OP_REM) ? neg1 : (neg1 ^ neg2);
    in_div0   = in_div && (mdu.mdu_rs2 == '0);
    in_ovf    = ((mdu.mdu_op == OP_DIV) || (mdu.mdu_op == OP_REM)) &&
                (mdu.mdu_rs1 == INT_MIN) && (mdu.mdu_rs2 == '1);
    in_mzero  = !in_div && ((mdu.mdu_rs1 == '0) || (mdu.mdu_rs2 == '0));
    in_special = in_div0 || in_ovf || in_mzero;
  end

  // One iteration step: shift-add multiply (multiplier in low half) or restoring divide
  logic [DATA_W:0]     mul_sum, rem_sh, diff;
  logic [2*DATA_W-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[DATA_W-1:1]};
    rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    diff     = rem_sh - {1'b0, a_q};
    div_next = diff[DATA_W] ? {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                            : {diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};
  end

  // Sign correction, word select and special-case override
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem  = neg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    case (op_q)
      OP_MUL:                         fix_res = prod[DATA_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = prod[2*DATA_W-1:DATA_W];
      OP_DIV, OP_DIVU:                fix_res = quo;
      default:                        fix_res = rem;
    endcase
    if (mzero_q) fix_res = '0;
    if (div0_q)  fix_res = op_q[1] ? rs1_q : '1;
    if (ovf_q)   fix_res = op_q[1] ? '0 : INT_MIN;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    acc_d    = acc_q;
    rs1_d    = rs1_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    mzero_d  = mzero_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    valid_d  = valid_q;

    case (state_q)
      S_IDLE: begin
        if (!mdu.mdu_flush && mdu.mdu_start) begin
          op_d    = mdu.mdu_op;
          rd_d    = mdu.mdu_rd;
          rs1_d   = mdu.mdu_rs1;
          neg_d   = in_neg;
          div0_d  = in_div0;
          ovf_d   = in_ovf;
          mzero_d = in_mzero;
          cnt_d   = '0;
          a_d     = in_div ? abs2 : abs1;
          acc_d   = {{DATA_W{1'b0}}, (in_div ? abs1 : abs2)};
`ifdef MDU_FAST_PATH_EN
          state_d = in_special ? S_FIX : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (mdu.mdu_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '1) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (mdu.mdu_flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          rd_out_d = rd_q;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (mdu.mdu_flush || mdu.mdu_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mdu_clk or negedge mdu_rst) begin
    if (!mdu_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge mdu_clk or negedge mdu_rst) begin
    if (!mdu_rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      rs1_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mzero_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      rs1_q    <= rs1_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      mzero_q  <= mzero_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      valid_q  <= valid_d;
    end
  end

  assign mdu.mdu_ready  = (state_q == S_IDLE);
  assign mdu.mdu_busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign mdu.mdu_valid  = valid_q;
  assign mdu.mdu_result = result_q;
  assign mdu.mdu_rd_out = rd_out_q;

  // The fast-path build is the only consumer of the combined special-case flag
  logic unused_special;
  assign unused_special = in_special;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: arithmetic table plus handshake, flush and reset sequences.
module tb_mdu_iter;
`ifdef MDU_FAST_PATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 33;
`endif
  localparam int SLOW_LAT = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  mdu_iter u_dut (
    .mdu_clk (clk),
    .mdu_rst (rst_n),
    .mdu     (bus.slave)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait for valid; lat counts edges after the accepting edge
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat);
    @(negedge clk);
    bus.mdu_op    = op;
    bus.mdu_rs1   = a;
    bus.mdu_rs2   = b;
    bus.mdu_rd    = rd;
    bus.mdu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mdu_start = 1'b0;
    bus.mdu_rs1   = ~a;
    bus.mdu_rs2   = a ^ b ^ 32'h5A5A_5A5A;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.mdu_valid) break;
    end
  endtask

  task automatic do_ack(input string name);
    bus.mdu_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mdu_ack = 1'b0;
    chk({name, "_ack_valid"}, {31'd0, bus.mdu_valid}, 32'd0);
    chk({name, "_ack_ready"}, {31'd0, bus.mdu_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int vcount;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 1'b0};
    vecs[4]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 1'b0};
    vecs[5]  = '{3'd0, 32'h0001_0000,  32'h0001_0000, 5'd6,  32'h0000_0000, 1'b0};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 1'b0};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{3'd5, 32'd100,        32'd7,         5'd9,  32'd14,        1'b0};
    vecs[9]  = '{3'd7, 32'd100,        32'd7,         5'd10, 32'd2,         1'b0};
    vecs[10] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 1'b0};
    vecs[11] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd12, 32'd1,         1'b0};
    vecs[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         1'b0};
    vecs[13] = '{3'd4, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1};
    vecs[14] = '{3'd6, 32'd5,          32'd0,         5'd15, 32'd5,         1'b1};
    vecs[15] = '{3'd5, 32'd5,          32'd0,         5'd16, 32'hFFFF_FFFF, 1'b1};
    vecs[16] = '{3'd7, 32'hDEAD_BEEF,  32'd0,         5'd17, 32'hDEAD_BEEF, 1'b1};
    vecs[17] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd18, 32'hFFFF_FFF9, 1'b1};
    vecs[18] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1'b1};
    vecs[19] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'd0,         1'b1};
    vecs[20] = '{3'd0, 32'd0,          32'd5,         5'd21, 32'd0,         1'b1};
    vecs[21] = '{3'd3, 32'd1234,       32'd0,         5'd22, 32'd0,         1'b1};

    bus.mdu_start = 1'b0;
    bus.mdu_op    = 3'd0;
    bus.mdu_rs1   = '0;
    bus.mdu_rs2   = '0;
    bus.mdu_rd    = '0;
    bus.mdu_flush = 1'b0;
    bus.mdu_ack   = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready",  {31'd0, bus.mdu_ready}, 32'd1);
    chk("rst_valid",  {31'd0, bus.mdu_valid}, 32'd0);
    chk("rst_busy",   {31'd0, bus.mdu_busy},  32'd0);
    chk("rst_result", bus.mdu_result, 32'd0);
    chk("rst_rd_out", {27'd0, bus.mdu_rd_out}, 32'd0);

    for (int i = 0; i < 22; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat);
      chk($sformatf("vec%0d_result", i), bus.mdu_result, vecs[i].exp);
      chk($sformatf("vec%0d_rd_out", i), {27'd0, bus.mdu_rd_out}, {27'd0, vecs[i].rd});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].fast ? FAST_LAT : SLOW_LAT);
      do_ack($sformatf("vec%0d", i));
    end

    // Backpressure: result held while ack stays low
    launch(3'd5, 32'd100, 32'd7, 5'd9, lat);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("hold%0d_valid", c), {31'd0, bus.mdu_valid}, 32'd1);
      chk($sformatf("hold%0d_result", c), bus.mdu_result, 32'd14);
      chk($sformatf("hold%0d_rd_out", c), {27'd0, bus.mdu_rd_out}, 32'd9);
      @(posedge clk);
      @(negedge clk);
    end
    // start together with ack must be ignored
    bus.mdu_op    = 3'd0;
    bus.mdu_rs1   = 32'd2;
    bus.mdu_rs2   = 32'd2;
    bus.mdu_start = 1'b1;
    bus.mdu_ack   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mdu_start = 1'b0;
    bus.mdu_ack   = 1'b0;
    chk("startack_ready", {31'd0, bus.mdu_ready}, 32'd1);
    chk("startack_valid", {31'd0, bus.mdu_valid}, 32'd0);
    chk("startack_busy",  {31'd0, bus.mdu_busy},  32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("startack_busy2", {31'd0, bus.mdu_busy}, 32'd0);

    // Flush in IDLE blocks a concurrent start
    bus.mdu_op    = 3'd0;
    bus.mdu_rs1   = 32'd3;
    bus.mdu_rs2   = 32'd3;
    bus.mdu_start = 1'b1;
    bus.mdu_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mdu_start = 1'b0;
    bus.mdu_flush = 1'b0;
    chk("idleflush_ready", {31'd0, bus.mdu_ready}, 32'd1);
    chk("idleflush_busy",  {31'd0, bus.mdu_busy},  32'd0);

    // Flush in DONE drops the result
    launch(3'd0, 32'd6, 32'd7, 5'd3, lat);
    chk("doneflush_pre", bus.mdu_result, 32'd42);
    bus.mdu_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mdu_flush = 1'b0;
    chk("doneflush_valid", {31'd0, bus.mdu_valid}, 32'd0);
    chk("doneflush_ready", {31'd0, bus.mdu_ready}, 32'd1);

    // Flush at CALC cycle 15
    bus.mdu_op    = 3'd0;
    bus.mdu_rs1   = 32'h1234_5678;
    bus.mdu_rs2   = 32'h09AB_CDEF;
    bus.mdu_rd    = 5'd30;
    bus.mdu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mdu_start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("calcflush_busy_pre", {31'd0, bus.mdu_busy}, 32'd1);
    bus.mdu_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mdu_flush = 1'b0;
    chk("calcflush_ready", {31'd0, bus.mdu_ready}, 32'd1);
    chk("calcflush_busy",  {31'd0, bus.mdu_busy},  32'd0);
    chk("calcflush_valid", {31'd0, bus.mdu_valid}, 32'd0);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.mdu_valid) vcount++;
    end
    chk("calcflush_no_valid", vcount, 32'd0);
    launch(3'd0, 32'd3, 32'd4, 5'd12, lat);
    chk("postflush_result", bus.mdu_result, 32'd12);
    chk("postflush_latency", lat, SLOW_LAT);
    do_ack("postflush");

    // Asynchronous reset at CALC cycle 20
    bus.mdu_op    = 3'd5;
    bus.mdu_rs1   = 32'd1000;
    bus.mdu_rs2   = 32'd10;
    bus.mdu_rd    = 5'd25;
    bus.mdu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mdu_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_busy_pre", {31'd0, bus.mdu_busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready",  {31'd0, bus.mdu_ready}, 32'd1);
    chk("midrst_valid",  {31'd0, bus.mdu_valid}, 32'd0);
    chk("midrst_busy",   {31'd0, bus.mdu_busy},  32'd0);
    chk("midrst_result", bus.mdu_result, 32'd0);
    chk("midrst_rd_out", {27'd0, bus.mdu_rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(3'd5, 32'd9, 32'd3, 5'd26, lat);
    chk("postrst_result", bus.mdu_result, 32'd3);
    chk("postrst_rd_out", {27'd0, bus.mdu_rd_out}, 32'd26);
    chk("postrst_latency", lat, SLOW_LAT);
    do_ack("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
